regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter NUM_REGS, default 32: register count, a power of 2 from 4 to 64; AW = log2(NUM_REGS).
REQ-003 Parameter NUM_READ, default 2: read-port count, 1 to 4.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 ctrl_reset_n  in  1  asynchronous, active-low reset.
REQ-006 ctrl_writeEnable  in  1  write request this cycle.
REQ-007 ctrl_writeReg  in  AW  write address.
REQ-008 data_writeReg  in  DATA_W  write data.
REQ-009 ctrl_readReg  in  NUM_READ*AW  packed read addresses; port k in bits [k*AW +: AW].
REQ-010 data_readReg  out  NUM_READ*DATA_W  packed read data; port k in bits [k*DATA_W +: DATA_W].
REQ-011 ctrl_reserve  in  1  mark the destination register pending.
REQ-012 ctrl_reserveReg  in  AW  register to reserve.
REQ-013 busy_read  out  NUM_READ  per-port pending flag for the addressed register.
REQ-014 ctrl_clear  in  1  start a sequential zero-fill sweep.
REQ-015 ready  out  1  high when state is IDLE; low during the sweep.

Function
REQ-016 Reads are combinational; data_readReg port k shows reg[addr_k] in the same cycle.
REQ-017 Register 0 always reads 0; writes and reservations to it are ignored; it is never busy.
REQ-018 Write: with ready high and ctrl_writeEnable high, reg[ctrl_writeReg] takes data_writeReg at the next rising edge.
REQ-019 Bypass: with ready high, ctrl_writeEnable high and addr_k equal to a nonzero ctrl_writeReg, port k returns data_writeReg in the same cycle.
REQ-020 Scoreboard: one busy bit per register; ctrl_reserve with ready high sets busy[ctrl_reserveReg] at the next edge.
REQ-021 An accepted write clears busy[ctrl_writeReg] at the next edge.
REQ-022 A reserve and a write to the same register in the same cycle leave busy set, because the newer reservation wins.
REQ-023 busy_read[k] = busy[addr_k] AND NOT (bypass active on port k); a port is therefore never busy when its data is being bypassed.
REQ-024 FSM states are IDLE and CLEAR.
  - IDLE to CLEAR when ctrl_clear is high; the sweep index loads 1.
  - In CLEAR, each cycle zeroes reg[index] and busy[index], then increments the index.
  - CLEAR to IDLE at the edge that zeroes index NUM_REGS-1; a sweep lasts NUM_REGS-1 cycles.
REQ-025 While in CLEAR:
  - ctrl_writeEnable, ctrl_reserve and ctrl_clear are ignored and no bypass occurs.
  - Reads return current array contents, so swept entries read 0.
REQ-026 An accepted write or reserve in the same cycle that ctrl_clear is accepted in IDLE takes effect; the sweep then zeroes that register.
REQ-027 Simultaneous reads from all ports of the same address are legal and return identical data.

Reset
REQ-028 ctrl_reset_n low asynchronously sets all registers to 0, all busy bits to 0, the state to IDLE and the sweep index to 1.
REQ-029 Reset values of outputs: data_readReg all 0, busy_read all 0, ready 1.
REQ-030 Reset asserted mid-sweep aborts the sweep; after release the block is in IDLE with all registers 0.

Structure
REQ-031 Shared package regfile_pkg holds:
  - the state enum {IDLE, CLEAR};
  - default values of DATA_W, NUM_REGS and NUM_READ;
  - the function used to derive AW.
REQ-032 A single sub-module regfile_cell holds one DATA_W-bit enabled register with async active-low reset; it is instantiated for entries 1..NUM_REGS-1.

Verification (DATA_W=32, NUM_REGS=32, NUM_READ=2)
REQ-033 Write 0xDEADBEEF to r5, then read both ports at r5 the next cycle -> both ports return 0xDEADBEEF.
REQ-034 Write 0x12345678 to r7 while port 0 reads r7 in the same cycle -> port 0 returns 0x12345678 (bypass) and busy_read[0]=0.
REQ-035 Write 0xFFFFFFFF to r0, then read r0; also reserve r0 -> port returns 0 and busy_read stays 0.
REQ-036 Reserve r9, then read r9 -> busy_read=1; in a later cycle, reserve and write r9 together -> busy stays 1; write r9 alone -> busy clears on the next cycle.
REQ-037 Fill r1..r31 with nonzero values, pulse ctrl_clear, and attempt a write to r3 during CLEAR -> ready is low for exactly 31 cycles, every register then reads 0 and the r3 write is ignored.
REQ-038 Assert ctrl_reset_n low 10 cycles into a sweep -> ready=1 and all reads return 0 after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the multi-port register file.
//   state_t       : sweep controller states (IDLE, CLEAR)
//   DEF_*         : default values for the regfile_mp parameters
//   addr_width()  : derives the address width from the register count
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_READ = 2;

  // Register counts are powers of two, so clog2 gives an exact address width.
  function automatic int addr_width(input int num_regs);
    return (num_regs <= 1) ? 1 : $clog2(num_regs);
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell -- one DATA_W-bit storage entry with load enable.
//   clock        : rising-edge clock
//   ctrl_reset_n : asynchronous active-low reset, clears q to 0
//   en           : load d into q at the next rising edge
//   d            : next value
//   q            : stored value
module regfile_cell #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // NOTE: clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- multi-read-port register file with write bypass, a
// per-register busy scoreboard and a sequential zero-fill sweep.
//   clock            : sole clock, rising edge
//   ctrl_reset_n     : asynchronous active-low reset
//   ctrl_writeEnable : write request (accepted only while ready)
//   ctrl_writeReg    : write address
//   data_writeReg    : write data
//   ctrl_readReg     : packed read addresses, port k at [k*AW +: AW]
//   data_readReg     : packed read data, port k at [k*DATA_W +: DATA_W]
//   ctrl_reserve     : mark ctrl_reserveReg pending (accepted only while ready)
//   ctrl_reserveReg  : register to reserve
//   busy_read        : per-port pending flag of the addressed register
//   ctrl_clear       : start the zero-fill sweep of entries 1..NUM_REGS-1
//   ready            : high in IDLE, low while sweeping
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_READ = DEF_NUM_READ,
  localparam int AW       = addr_width(NUM_REGS)
) (
  input  logic                       clock,
  input  logic                       ctrl_reset_n,
  input  logic                       ctrl_writeEnable,
  input  logic [AW-1:0]              ctrl_writeReg,
  input  logic [DATA_W-1:0]          data_writeReg,
  input  logic [NUM_READ*AW-1:0]     ctrl_readReg,
  output logic [NUM_READ*DATA_W-1:0] data_readReg,
  input  logic                       ctrl_reserve,
  input  logic [AW-1:0]              ctrl_reserveReg,
  output logic [NUM_READ-1:0]        busy_read,
  input  logic                       ctrl_clear,
  output logic                       ready
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   sweep_idx;
  logic [AW-1:0]   sweep_idx_next;
  logic            clearing;
  logic            wr_acc;
  logic            rsv_acc;

  // Register 0 is hard-wired to zero, so entry 0 has no storage and no busy bit.
  logic [NUM_REGS-1:1] cell_en;
  logic [DATA_W-1:0]   cell_d;
  logic [DATA_W-1:0]   cell_q [1:NUM_REGS-1];
  logic [DATA_W-1:0]   rd_array [NUM_REGS];
  logic [NUM_REGS-1:1] busy_q;
  logic [NUM_REGS-1:0] busy_vec;

  assign ready    = (state == IDLE);
  assign clearing = (state == CLEAR);

  // Requests are only honoured in IDLE; anything addressed to r0 is dropped.
  assign wr_acc  = ready && ctrl_writeEnable && (ctrl_writeReg != '0);
  assign rsv_acc = ready && ctrl_reserve && (ctrl_reserveReg != '0);

  // ---------------------------------------------------------------------------
  // Sweep controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state     <= IDLE;
      sweep_idx <= FIRST_IDX;
    end else begin
      state     <= state_next;
      sweep_idx <= sweep_idx_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next     = state;
    sweep_idx_next = sweep_idx;
    unique case (state)
      IDLE: begin
        if (ctrl_clear) begin
          state_next     = CLEAR;
          sweep_idx_next = FIRST_IDX;
        end
      end
      CLEAR: begin
        if (sweep_idx == LAST_IDX) begin
          state_next     = IDLE;
          sweep_idx_next = FIRST_IDX;
        end else begin
          sweep_idx_next = sweep_idx + FIRST_IDX;
        end
      end
      default: begin
        state_next     = IDLE;
        sweep_idx_next = FIRST_IDX;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage: the sweep and an accepted write never coincide, since writes are
  // only accepted in IDLE, so a single data mux suffices.
  // ---------------------------------------------------------------------------
  assign cell_d = clearing ? '0 : data_writeReg;

  always_comb begin
    cell_en = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cell_en[i] = (wr_acc && (ctrl_writeReg == AW'(i))) ||
                   (clearing && (sweep_idx == AW'(i)));
    end
  end

  // NOTE: the entries are individual flops with async reset rather than an
  // inferred RAM, because reset must clear the whole array at once.
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_cell
    regfile_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clock        (clock),
      .ctrl_reset_n (ctrl_reset_n),
      .en           (cell_en[g]),
      .d            (cell_d),
      .q            (cell_q[g])
    );
  end

  always_comb begin
    rd_array[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_array[i] = cell_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Priority: sweep clear, then reservation (the newer
  // producer), then write completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      busy_q <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (clearing && (sweep_idx == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end else if (rsv_acc && (ctrl_reserveReg == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr_acc && (ctrl_writeReg == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_vec = {busy_q, 1'b0};

  // ---------------------------------------------------------------------------
  // Read ports. A port whose address matches an accepted write sees the write
  // data now and is never reported busy, since its value is already available.
  // ---------------------------------------------------------------------------
  always_comb begin
    data_readReg = '0;
    busy_read    = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (wr_acc && (ctrl_readReg[k*AW +: AW] == ctrl_writeReg)) begin
        data_readReg[k*DATA_W +: DATA_W] = data_writeReg;
        busy_read[k]                     = 1'b0;
      end else begin
        data_readReg[k*DATA_W +: DATA_W] = rd_array[ctrl_readReg[k*AW +: AW]];
        busy_read[k]                     = busy_vec[ctrl_readReg[k*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp with
// DATA_W=32, NUM_REGS=32, NUM_READ=2.
module tb_regfile_mp;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [9:0]  ctrl_readReg;
  logic [63:0] data_readReg;
  logic        ctrl_reserve;
  logic [4:0]  ctrl_reserveReg;
  logic [1:0]  busy_read;
  logic        ctrl_clear;
  logic        ready;

  int vectors;
  int miscompares;
  int ready_low;

  regfile_mp #(
    .DATA_W   (32),
    .NUM_REGS (32),
    .NUM_READ (2)
  ) dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readReg     (ctrl_readReg),
    .data_readReg     (data_readReg),
    .ctrl_reserve     (ctrl_reserve),
    .ctrl_reserveReg  (ctrl_reserveReg),
    .busy_read        (busy_read),
    .ctrl_clear       (ctrl_clear),
    .ready            (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_read(input logic [4:0] a0, input logic [4:0] a1);
    ctrl_readReg = {a1, a0};
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'hC000_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  initial begin
    vectors          = 0;
    miscompares      = 0;
    ctrl_reset_n     = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readReg     = '0;
    ctrl_reserve     = 1'b0;
    ctrl_reserveReg  = '0;
    ctrl_clear       = 1'b0;
    set_read(5'd3, 5'd5);

    // Reset state
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_data", data_readReg, 64'd0);
    check("rst_busy", 64'(busy_read), 64'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    tick();

    // Write r5, read it on both ports next cycle
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd5;
    data_writeReg    = 32'hDEAD_BEEF;
    tick();
    ctrl_writeEnable = 1'b0;
    set_read(5'd5, 5'd5);
    #1;
    check("r5_both", data_readReg, {32'hDEAD_BEEF, 32'hDEAD_BEEF});

    // Same-cycle bypass on port 0; port 1 reads stored r5
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h1234_5678;
    set_read(5'd7, 5'd5);
    #1;
    check("byp_r7", data_readReg, {32'hDEAD_BEEF, 32'h1234_5678});
    check("byp_busy", 64'(busy_read), 64'd0);
    tick();
    ctrl_writeEnable = 1'b0;
    set_read(5'd5, 5'd7);
    #1;
    check("r7_stored", data_readReg, {32'h1234_5678, 32'hDEAD_BEEF});

    // r0: write and reserve ignored, no bypass
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'hFFFF_FFFF;
    ctrl_reserve     = 1'b1;
    ctrl_reserveReg  = 5'd0;
    set_read(5'd0, 5'd0);
    #1;
    check("r0_nobyp", data_readReg, 64'd0);
    tick();
    ctrl_writeEnable = 1'b0;
    ctrl_reserve     = 1'b0;
    #1;
    check("r0_data", data_readReg, 64'd0);
    check("r0_busy", 64'(busy_read), 64'd0);

    // Scoreboard on r9
    ctrl_reserve    = 1'b1;
    ctrl_reserveReg = 5'd9;
    tick();
    ctrl_reserve = 1'b0;
    set_read(5'd9, 5'd9);
    #1;
    check("r9_busy", 64'(busy_read), 64'd3);
    ctrl_reserve     = 1'b1;
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'hA5A5_A5A5;
    #1;
    check("r9_rw_byp", 64'(busy_read), 64'd0);
    check("r9_rw_data", data_readReg, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    tick();
    ctrl_reserve     = 1'b0;
    ctrl_writeEnable = 1'b0;
    #1;
    check("r9_rsv_wins", 64'(busy_read), 64'd3);
    check("r9_rw_store", data_readReg, {32'hA5A5_A5A5, 32'hA5A5_A5A5});
    ctrl_writeEnable = 1'b1;
    data_writeReg    = 32'h5A5A_5A5A;
    tick();
    ctrl_writeEnable = 1'b0;
    #1;
    check("r9_wr_clear", 64'(busy_read), 64'd0);
    check("r9_wr_data", data_readReg, {32'h5A5A_5A5A, 32'h5A5A_5A5A});

    // Fill r1..r31, reserve r12, then sweep
    for (int i = 1; i < 32; i++) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = 5'(i);
      data_writeReg    = fill_val(i);
      tick();
    end
    ctrl_writeEnable = 1'b0;
    ctrl_reserve     = 1'b1;
    ctrl_reserveReg  = 5'd12;
    set_read(5'd3, 5'd31);
    #1;
    check("fill_r3_r31", data_readReg, {fill_val(31), fill_val(3)});
    tick();
    ctrl_reserve = 1'b0;
    ctrl_clear   = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    // Attempted write to r3 held throughout the sweep must be ignored.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h0BAD_0BAD;
    set_read(5'd31, 5'd3);
    #1;
    check("clr_no_byp", data_readReg, {fill_val(3), fill_val(31)});
    ready_low = 0;
    while (!ready && ready_low < 100) begin
      ready_low++;
      tick();
    end
    ctrl_writeEnable = 1'b0;
    check("clr_cycles", 64'(ready_low), 64'd31);
    for (int i = 0; i < 32; i++) begin
      set_read(5'(i), 5'(31 - i));
      #1;
      check($sformatf("clr_zero_%0d", i), data_readReg, 64'd0);
    end
    set_read(5'd12, 5'd12);
    #1;
    check("clr_busy12", 64'(busy_read), 64'd0);

    // Reset 10 cycles into a sweep
    tick();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd20;
    data_writeReg    = 32'h2222_2222;
    ctrl_reserve     = 1'b1;
    ctrl_reserveReg  = 5'd20;
    tick();
    ctrl_writeEnable = 1'b0;
    ctrl_reserve     = 1'b0;
    set_read(5'd20, 5'd20);
    #1;
    check("pre_r20", data_readReg, {32'h2222_2222, 32'h2222_2222});
    check("pre_busy20", 64'(busy_read), 64'd3);
    ctrl_clear = 1'b1;
    tick();
    ctrl_clear = 1'b0;
    repeat (10) tick();
    check("mid_sweep", 64'(ready), 64'd0);
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready), 64'd1);
    check("rst_mid_data", data_readReg, 64'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    tick();
    check("post_ready", 64'(ready), 64'd1);
    check("post_data", data_readReg, 64'd0);
    check("post_busy", 64'(busy_read), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
